// File: rtl/axi_rr_arbiter.sv
// axi_priority_encoder / axi_rr_arbiter
//
// axi_priority_encoder: combinational priority encoder.
//   input_unencoded  [WIDTH]  request vector
//   output_valid              any input bit set
//   output_encoded   [EW]     index of the winning bit (0 when none)
//   output_unencoded [WIDTH]  one-hot of the winning bit (0 when none)
//   LSB_PRIORITY "HIGH" -> lowest set index wins, "LOW" -> highest wins.
//
// axi_rr_arbiter: round-robin / fixed-priority arbiter with registered grant.
//   clk            clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   request        [PORTS] per-port request level
//   acknowledge    [PORTS] per-port burst-done pulse (only the grantee's bit counts)
//   grant          [PORTS] registered one-hot grant
//   grant_valid            registered, 1 when any grant bit is set
//   grant_encoded  [GW]    registered binary index of grant

module axi_priority_encoder #(
    parameter int unsigned WIDTH        = 4,
    parameter              LSB_PRIORITY = "HIGH",
    localparam int unsigned EW          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] input_unencoded,
    output logic             output_valid,
    output logic [EW-1:0]    output_encoded,
    output logic [WIDTH-1:0] output_unencoded
);

    localparam bit LSB_HIGH = (LSB_PRIORITY == "HIGH");

    // Scan so that the preferred bit is visited last; its assignment sticks.
    always_comb begin
        output_valid     = |input_unencoded;
        output_encoded   = '0;
        output_unencoded = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (LSB_HIGH) begin
                if (input_unencoded[WIDTH-1-i]) begin
                    output_encoded = EW'(WIDTH - 1 - i);
                end
            end else begin
                if (input_unencoded[i]) begin
                    output_encoded = EW'(i);
                end
            end
        end
        if (output_valid) begin
            output_unencoded[output_encoded] = 1'b1;
        end
    end

endmodule

module axi_rr_arbiter #(
    parameter int unsigned PORTS                = 4,
    parameter int unsigned ARB_TYPE_ROUND_ROBIN = 1,
    parameter int unsigned ARB_BLOCK            = 1,
    parameter int unsigned ARB_BLOCK_ACK        = 1,
    parameter              LSB_PRIORITY         = "HIGH",
    localparam int unsigned GW                  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] request,
    input  logic [PORTS-1:0] acknowledge,
    output logic [PORTS-1:0] grant,
    output logic             grant_valid,
    output logic [GW-1:0]    grant_encoded
);

    localparam bit LSB_HIGH = (LSB_PRIORITY == "HIGH");

    logic [PORTS-1:0] grant_q, grant_d;
    logic             grant_valid_q, grant_valid_d;
    logic [GW-1:0]    grant_encoded_q, grant_encoded_d;
    logic [PORTS-1:0] mask_q, mask_d;

    logic [PORTS-1:0] masked_request;
    logic             req_valid, masked_valid;
    logic [GW-1:0]    req_encoded, masked_encoded;
    logic [PORTS-1:0] req_unencoded, masked_unencoded;
    logic             hold;

    always_comb begin
        masked_request = request & mask_q;
    end

    axi_priority_encoder #(
        .WIDTH        (PORTS),
        .LSB_PRIORITY (LSB_PRIORITY)
    ) u_req_enc (
        .input_unencoded  (request),
        .output_valid     (req_valid),
        .output_encoded   (req_encoded),
        .output_unencoded (req_unencoded)
    );

    axi_priority_encoder #(
        .WIDTH        (PORTS),
        .LSB_PRIORITY (LSB_PRIORITY)
    ) u_masked_enc (
        .input_unencoded  (masked_request),
        .output_valid     (masked_valid),
        .output_encoded   (masked_encoded),
        .output_unencoded (masked_unencoded)
    );

    always_comb begin
        hold = 1'b0;
        if (ARB_BLOCK != 0) begin
            if (ARB_BLOCK_ACK != 0) begin
                // Held until the grantee acknowledges, even if it drops request.
                hold = grant_valid_q && ((grant_q & acknowledge) == '0);
            end else begin
                hold = grant_valid_q && ((grant_q & request) != '0);
            end
        end
    end

    always_comb begin
        grant_d         = grant_q;
        grant_valid_d   = grant_valid_q;
        grant_encoded_d = grant_encoded_q;
        mask_d          = mask_q;
        if (!hold) begin
            if (req_valid) begin
                grant_valid_d = 1'b1;
                if ((ARB_TYPE_ROUND_ROBIN != 0) && masked_valid) begin
                    grant_d         = masked_unencoded;
                    grant_encoded_d = masked_encoded;
                end else begin
                    grant_d         = req_unencoded;
                    grant_encoded_d = req_encoded;
                end
                if (ARB_TYPE_ROUND_ROBIN != 0) begin
                    // Mask covers only ports after the new grantee in priority
                    // order; it becomes empty when the grantee is the last one.
                    for (int unsigned i = 0; i < PORTS; i++) begin
                        if (LSB_HIGH) begin
                            mask_d[i] = (i > 32'(grant_encoded_d));
                        end else begin
                            mask_d[i] = (i < 32'(grant_encoded_d));
                        end
                    end
                end
            end else begin
                grant_d         = '0;
                grant_valid_d   = 1'b0;
                grant_encoded_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q         <= '0;
            grant_valid_q   <= 1'b0;
            grant_encoded_q <= '0;
            mask_q          <= '0;
        end else begin
            grant_q         <= grant_d;
            grant_valid_q   <= grant_valid_d;
            grant_encoded_q <= grant_encoded_d;
            mask_q          <= mask_d;
        end
    end

    always_comb begin
        grant         = grant_q;
        grant_valid   = grant_valid_q;
        grant_encoded = grant_encoded_q;
    end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Bench for axi_rr_arbiter: directed vector table, hand-written reset
// sequences, and randomized traffic against a pointer-based reference model.

module tb_axi_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n, rst2_n;
    logic [3:0] req, ack, req2, ack2;
    logic [3:0] gnt, gnt2;
    logic       gv, gv2;
    logic [1:0] ge, ge2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_rr_arbiter #(
        .PORTS                (4),
        .ARB_TYPE_ROUND_ROBIN (1),
        .ARB_BLOCK            (1),
        .ARB_BLOCK_ACK        (1),
        .LSB_PRIORITY         ("HIGH")
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .request       (req),
        .acknowledge   (ack),
        .grant         (gnt),
        .grant_valid   (gv),
        .grant_encoded (ge)
    );

    axi_rr_arbiter #(
        .PORTS                (4),
        .ARB_TYPE_ROUND_ROBIN (1),
        .ARB_BLOCK            (0),
        .ARB_BLOCK_ACK        (1),
        .LSB_PRIORITY         ("HIGH")
    ) dut_nb (
        .clk           (clk),
        .rst_n         (rst2_n),
        .request       (req2),
        .acknowledge   (ack2),
        .grant         (gnt2),
        .grant_valid   (gv2),
        .grant_encoded (ge2)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] ack;
        logic [3:0] grant;
        logic       valid;
        logic [1:0] enc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_main(input string name, input logic [3:0] g, input logic v, input logic [1:0] e);
        check({name, ".grant"}, 32'(gnt), 32'(g));
        check({name, ".valid"}, 32'(gv), 32'(v));
        check({name, ".enc"}, 32'(ge), 32'(e));
    endtask

    task automatic check_nb(input string name, input logic [3:0] g, input logic v, input logic [1:0] e);
        check({name, ".grant"}, 32'(gnt2), 32'(g));
        check({name, ".valid"}, 32'(gv2), 32'(v));
        check({name, ".enc"}, 32'(ge2), 32'(e));
    endtask

    // Advance one clock and settle away from the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a grant index (-1 = none) and a search start pointer.
    // Round-robin means search cyclically from one past the last winner.
    int m_gi, m_ptr, n_gi, n_ptr;

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (start + k) % 4;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int gi);
        logic [3:0] v;
        v = '0;
        if (gi >= 0) v[gi] = 1'b1;
        return v;
    endfunction

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        req    = 4'b1111;
        ack    = 4'b0000;
        req2   = 4'b0000;
        ack2   = 4'b0000;

        // Directed table (rows applied one per cycle after reset release).
        vecs.push_back('{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0});
        vecs.push_back('{4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0});
        vecs.push_back('{4'b1010, 4'b0000, 4'b0010, 1'b1, 2'd1});
        for (int i = 0; i < 6; i++)
            vecs.push_back('{4'b1010, 4'b0000, 4'b0010, 1'b1, 2'd1});
        vecs.push_back('{4'b1000, 4'b0000, 4'b0010, 1'b1, 2'd1});
        vecs.push_back('{4'b1010, 4'b0010, 4'b1000, 1'b1, 2'd3});
        vecs.push_back('{4'b1011, 4'b1000, 4'b0001, 1'b1, 2'd0});
        vecs.push_back('{4'b1011, 4'b0001, 4'b0010, 1'b1, 2'd1});
        vecs.push_back('{4'b1011, 4'b0010, 4'b1000, 1'b1, 2'd3});
        vecs.push_back('{4'b1011, 4'b1000, 4'b0001, 1'b1, 2'd0});
        vecs.push_back('{4'b1011, 4'b0100, 4'b0001, 1'b1, 2'd0});
        vecs.push_back('{4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0});
        vecs.push_back('{4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0});

        // Reset held with all requests asserted: outputs stay zero.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_main("reset_hold", 4'b0000, 1'b0, 2'd0);
        end
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            req = vecs[i].req;
            ack = vecs[i].ack;
            tick();
            check_main($sformatf("vec%0d", i), vecs[i].grant, vecs[i].valid, vecs[i].enc);
        end

        // Async reset while grant=0100 is held.
        req = 4'b0100; ack = 4'b0001;
        tick();
        check_main("mid_grant", 4'b0100, 1'b1, 2'd2);
        ack = 4'b0000;
        tick();
        check_main("mid_hold", 4'b0100, 1'b1, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_main("async_rst", 4'b0000, 1'b0, 2'd0);
        req = 4'b1100;
        tick();
        check_main("async_rst_edge", 4'b0000, 1'b0, 2'd0);
        rst_n = 1'b1;
        tick();
        check_main("post_rst_mask_clr", 4'b0100, 1'b1, 2'd2);

        // Non-blocking instance: alternates between the two requesters.
        check_nb("nb_reset", 4'b0000, 1'b0, 2'd0);
        req2 = 4'b0011;
        rst2_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i % 2 == 0) check_nb($sformatf("nb_alt%0d", i), 4'b0001, 1'b1, 2'd0);
            else            check_nb($sformatf("nb_alt%0d", i), 4'b0010, 1'b1, 2'd1);
        end

        // Randomized traffic on both instances against the model.
        rst_n = 1'b0; rst2_n = 1'b0;
        req = '0; ack = '0; req2 = '0; ack2 = '0;
        tick();
        rst_n = 1'b1; rst2_n = 1'b1;
        m_gi = -1; m_ptr = 0; n_gi = -1; n_ptr = 0;
        for (int c = 0; c < 400; c++) begin
            logic [3:0] r, a;
            int w;
            r = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            a = '0;
            if (m_gi >= 0 && $urandom_range(0, 2) == 0) a = onehot(m_gi);
            if ($urandom_range(0, 3) == 0) a = a | 4'($urandom_range(0, 15));
            req = r; ack = a; req2 = r; ack2 = a;

            if (!(m_gi >= 0 && a[m_gi])) begin
                if (m_gi < 0) begin
                    w = pick(r, m_ptr);
                    m_gi = w;
                    if (w >= 0) m_ptr = (w + 1) % 4;
                end
            end else begin
                w = pick(r, m_ptr);
                m_gi = w;
                if (w >= 0) m_ptr = (w + 1) % 4;
            end
            w = pick(r, n_ptr);
            n_gi = w;
            if (w >= 0) n_ptr = (w + 1) % 4;

            tick();
            check_main($sformatf("rnd_blk%0d", c), onehot(m_gi), m_gi >= 0,
                       (m_gi >= 0) ? 2'(m_gi) : 2'd0);
            check_nb($sformatf("rnd_nb%0d", c), onehot(n_gi), n_gi >= 0,
                     (n_gi >= 0) ? 2'(n_gi) : 2'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
